// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state type and constants for the program-counter unit
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_e;
  localparam int PC_STEP_DEFAULT = 4;
  localparam int BRANCH_CNT_W = 16;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority select (halt > stall > jump > branch > sequential)
module pc_next_sel #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus_step,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  output logic [WIDTH-1:0] next_pc,
  output logic             misaligned,
  output logic             redirect
);
  logic [WIDTH-1:0] tgt;
  // a redirect is accepted only when nothing above it holds the PC; jump wins the target
  always_comb begin
    redirect = !halt && !stall && (jump || branch);
    tgt = jump ? jump_target : branch_target;
    misaligned = redirect && (tgt[1:0] != 2'b00);
    next_pc = (halt || stall) ? pc : redirect ? {tgt[WIDTH-1:2], 2'b00} : pc_plus_step;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC with BOOT/RUN/HALTED FSM; optional BranchCount output under PC_BRANCH_STATS_EN
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = PC_STEP_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic [WIDTH-1:0] JumpTarget,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlusStep,
  output logic             Valid,
  output logic             Halted,
  output logic             Misaligned
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [BRANCH_CNT_W-1:0] BranchCount
`endif
);
  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, sel_pc;
  logic             mis_q, mis_d, sel_mis, sel_redirect;

  assign PC         = pc_q;
  assign PCPlusStep = pc_q + WIDTH'(STEP);
  assign Valid      = state_q == RUN;
  assign Halted     = state_q == HALTED;
  assign Misaligned = mis_q;

  pc_next_sel #(.WIDTH(WIDTH)) u_sel (
    .pc            (pc_q),
    .pc_plus_step  (PCPlusStep),
    .branch_target (BranchTarget),
    .jump_target   (JumpTarget),
    .halt          (Halt),
    .stall         (Stall),
    .jump          (Jump),
    .branch        (Branch),
    .next_pc       (sel_pc),
    .misaligned    (sel_mis),
    .redirect      (sel_redirect)
  );

  // BOOT holds the reset vector for one cycle; only RUN advances the PC; HALTED waits for reset
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        pc_d    = sel_pc;
        mis_d   = sel_mis;
        state_d = Halt ? HALTED : RUN;
      end
      default: state_d = HALTED;
    endcase
  end

  // state, PC and misalignment pulse registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [BRANCH_CNT_W-1:0] cnt_q, cnt_d;
  assign BranchCount = cnt_q;

  // saturating count of accepted redirects
  always_comb cnt_d = (state_q == RUN && sel_redirect && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  // redirect counter register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_redirect;
  assign unused_redirect = sel_redirect;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit
module tb_pc_unit;
  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic        m;
  } exp_t;

  logic        Clock = 1'b0, Reset_n = 1'b0;
  logic        Halt = 1'b0, Stall = 1'b0, Jump = 1'b0, Branch = 1'b0;
  logic [31:0] BranchTarget = '0, JumpTarget = '0;
  logic [31:0] PC, PCPlusStep;
  logic        Valid, Halted, Misaligned;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] BranchCount;
`endif
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .STEP(4)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Halt         (Halt),
    .Stall        (Stall),
    .Jump         (Jump),
    .Branch       (Branch),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .PC           (PC),
    .PCPlusStep   (PCPlusStep),
    .Valid        (Valid),
    .Halted       (Halted),
    .Misaligned   (Misaligned)
`ifdef PC_BRANCH_STATS_EN
    ,
    .BranchCount  (BranchCount)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic expect_now(input logic [31:0] pc, input logic v, input logic h, input logic m);
    exp_t e;
    e.pc = pc; e.v = v; e.h = h; e.m = m;
    q.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    n_chk++;
    assert (PC === e.pc) else begin n_fail++; $error("FAIL %s pc: got %h want %h", tag, PC, e.pc); end
    n_chk++;
    assert (PCPlusStep === e.pc + 32'd4) else begin n_fail++; $error("FAIL %s pcplus: got %h want %h", tag, PCPlusStep, e.pc + 32'd4); end
    n_chk++;
    assert (Valid === e.v) else begin n_fail++; $error("FAIL %s valid: got %b want %b", tag, Valid, e.v); end
    n_chk++;
    assert (Halted === e.h) else begin n_fail++; $error("FAIL %s halted: got %b want %b", tag, Halted, e.h); end
    n_chk++;
    assert (Misaligned === e.m) else begin n_fail++; $error("FAIL %s mis: got %b want %b", tag, Misaligned, e.m); end
  endtask

  task automatic cyc(input string tag, input logic h, input logic s, input logic j, input logic b,
                     input logic [31:0] bt, input logic [31:0] jt,
                     input logic [31:0] pc, input logic v, input logic hh, input logic m);
    Halt = h; Stall = s; Jump = j; Branch = b; BranchTarget = bt; JumpTarget = jt;
    expect_now(pc, v, hh, m);
    @(posedge Clock); #1;
    chk(tag);
  endtask

  task automatic idle(input string tag, input logic [31:0] pc, input logic v, input logic hh, input logic m);
    cyc(tag, 0, 0, 0, 0, '0, '0, pc, v, hh, m);
  endtask

`ifdef PC_BRANCH_STATS_EN
  task automatic chk_cnt(input string tag, input logic [15:0] want);
    n_chk++;
    assert (BranchCount === want) else begin n_fail++; $error("FAIL %s count: got %0d want %0d", tag, BranchCount, want); end
  endtask
`endif

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    expect_now(32'h100, 0, 0, 0); chk("in_reset");
    Reset_n = 1'b1;
    expect_now(32'h100, 0, 0, 0); chk("boot");
`ifdef PC_BRANCH_STATS_EN
    chk_cnt("cnt_reset", 16'd0);
`endif
    idle("run0", 32'h100, 1, 0, 0);
    idle("seq1", 32'h104, 1, 0, 0);
    idle("seq2", 32'h108, 1, 0, 0);
    cyc("jmp200", 0, 0, 1, 0, '0, 32'h200, 32'h200, 1, 0, 0);
    cyc("br400", 0, 0, 0, 1, 32'h400, '0, 32'h400, 1, 0, 0);
    idle("seq404", 32'h404, 1, 0, 0);
    cyc("jmp_br", 0, 0, 1, 1, 32'h401, 32'h800, 32'h800, 1, 0, 0);
`ifdef PC_BRANCH_STATS_EN
    chk_cnt("cnt3", 16'd3);
`endif
    cyc("jmp303", 0, 0, 1, 0, '0, 32'h303, 32'h300, 1, 0, 1);
    idle("mis_clear", 32'h304, 1, 0, 0);
    cyc("br402", 0, 0, 0, 1, 32'h402, '0, 32'h400, 1, 0, 1);
    cyc("jmp_wrap", 0, 0, 1, 0, '0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 0);
    idle("seq_fffc", 32'hFFFF_FFFC, 1, 0, 0);
    idle("wrap0", 32'h0, 1, 0, 0);
    cyc("stall_br", 0, 1, 0, 1, 32'h400, '0, 32'h0, 1, 0, 0);
    cyc("stall_jmp", 0, 1, 1, 0, '0, 32'h303, 32'h0, 1, 0, 0);
    cyc("halt", 1, 1, 1, 0, '0, 32'h800, 32'h0, 0, 1, 0);
    cyc("halted_jmp", 0, 0, 1, 1, 32'h400, 32'h803, 32'h0, 0, 1, 0);
    idle("halted_idle", 32'h0, 0, 1, 0);
`ifdef PC_BRANCH_STATS_EN
    chk_cnt("cnt_halted", 16'd6);
`endif
    Reset_n = 1'b0; #1;
    expect_now(32'h100, 0, 0, 0); chk("rst_halted");
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    expect_now(32'h100, 0, 0, 0); chk("reboot");
    idle("rerun", 32'h100, 1, 0, 0);
    Halt = 0; Stall = 0; Jump = 1; Branch = 0; JumpTarget = 32'h303;
    #1 Reset_n = 1'b0;
    @(posedge Clock); #1;
    Jump = 0; JumpTarget = '0;
    Reset_n = 1'b1;
    expect_now(32'h100, 0, 0, 0); chk("rst_redirect");
`ifdef PC_BRANCH_STATS_EN
    chk_cnt("cnt_rst", 16'd0);
`endif
    idle("rerun2", 32'h100, 1, 0, 0);
    idle("reseq", 32'h104, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: PC width in bits.
REQ-002 The block SHALL take parameter RESET_VECTOR, default 0: PC value after reset.
REQ-003 The block SHALL take parameter STEP, default 4: sequential increment.
REQ-004 The block SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port Halt  input  1  request to stop fetching.
REQ-007 The block SHALL have port Stall  input  1  hold the current PC.
REQ-008 The block SHALL have port Jump  input  1  redirect to JumpTarget.
REQ-009 The block SHALL have port Branch  input  1  branch taken, the select for the branch/sequential choice.
REQ-010 The block SHALL have port BranchTarget  input  WIDTH  branch destination.
REQ-011 The block SHALL have port JumpTarget  input  WIDTH  jump destination.
REQ-012 The block SHALL have port PC  output  WIDTH  current fetch address.
REQ-013 The block SHALL have port PCPlusStep  output  WIDTH  combinational PC+STEP.
REQ-014 The block SHALL have port Valid  output  1  PC is a valid fetch address this cycle.
REQ-015 The block SHALL have port Halted  output  1  block is in HALTED.
REQ-016 The block SHALL have port Misaligned  output  1  one-cycle pulse: the last redirect target had nonzero low bits.

Function
REQ-017 The block SHALL implement FSM states BOOT, RUN and HALTED.
REQ-018 BOOT SHALL last exactly one cycle after Reset_n deasserts, with PC=RESET_VECTOR and Valid=0, then move to RUN.
REQ-019 In RUN, next-PC priority SHALL be: Halt > Stall > Jump > Branch > sequential (PC+STEP).
REQ-020 In RUN with Halt=1, PC SHALL hold, the state SHALL move to HALTED, and Valid SHALL go to 0 from the next cycle.
REQ-021 HALTED SHALL be exited only by reset; all other inputs SHALL be ignored, and PC SHALL hold.
REQ-022 With Stall=1 and Halt=0, PC SHALL hold and Valid SHALL remain 1.
REQ-023 A redirect (Jump or Branch) SHALL take effect on the next edge: latency 1 cycle, with no bubble.
REQ-024 Redirect targets SHALL have bits [1:0] forced to 0; if those bits were nonzero, Misaligned SHALL be 1 for exactly the following cycle.
REQ-025 PC+STEP SHALL wrap modulo 2^WIDTH, with no flag raised on wrap.
REQ-026 Jump and Branch asserted in the same cycle SHALL select JumpTarget, and Misaligned SHALL evaluate JumpTarget only.
REQ-027 Stall and a redirect asserted in the same cycle SHALL drop the redirect; the producer re-presents it.
REQ-028 PCPlusStep SHALL always equal PC+STEP (wrapped), in every state.

Reset
REQ-029 Reset_n low SHALL immediately force PC=RESET_VECTOR, state=BOOT, Valid=0, Halted=0, Misaligned=0.
REQ-030 Reset asserted mid-operation, including while in HALTED or during a redirect, SHALL abort it with no residual effect after release.

Configuration
REQ-031 With macro PC_BRANCH_STATS_EN defined, the block SHALL add output BranchCount (16 bits), reset to 0, which increments on each accepted Branch or Jump and saturates at 16'hFFFF.
REQ-032 Without PC_BRANCH_STATS_EN, BranchCount and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package pc_pkg SHALL hold the FSM state enum (BOOT/RUN/HALTED), the default STEP, and the BranchCount width constant.
REQ-034 Next-PC selection SHALL live in the sub-module pc_next_sel (combinational; inputs are PC, targets and controls, output is the next PC plus a misalignment flag), instantiated once.

Verification
REQ-035 Release reset with RESET_VECTOR=0x100 and idle inputs -> PC reads 0x100 (Valid=0), then 0x100 (Valid=1), 0x104, 0x108.
REQ-036 At PC=0x200, pulse Branch=1 with BranchTarget=0x400 -> next PC is 0x400, then 0x404.
REQ-037 Assert Jump=1 (JumpTarget=0x800) and Branch=1 (BranchTarget=0x400) together -> PC=0x800; with the macro defined, BranchCount increments by 1.
REQ-038 Jump to JumpTarget=0x303 -> PC=0x300 and Misaligned=1 for exactly one cycle.
REQ-039 At PC=0xFFFFFFFC, run sequentially -> PC wraps to 0x0; then assert Stall with Branch -> PC holds at 0x0 and the branch is ignored.
REQ-040 Assert Halt -> Halted=1 and Valid=0 from the next cycle, PC frozen; pulse Reset_n low mid-HALTED -> PC=RESET_VECTOR immediately and the BOOT sequence repeats.
